// File: rtl/sram_arb_pkg.sv
// Shared widths, write-queue entry type and grant encoding for the frame-buffer SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned DATA_W       = 17;
    localparam int unsigned READ_LATENCY = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_RD,
        GNT_WR
    } gnt_e;

endpackage

// File: rtl/sram_arb_wr_fifo.sv
// Synchronous write-request FIFO; flags decode a registered occupancy count, head is never bypassed.
module sram_arb_wr_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wr_entry_t i_data,
    input  logic      i_pop,
    output wr_entry_t o_head_c,
    output logic      o_full_c,
    output logic      o_empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wr_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single-ported frame-buffer SRAM: priority reads, queued writes, starvation guard.
// Define SRAM_ARB_STATS_EN to add 32-bit grant/stall statistics counters.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WR_FIFO_DEPTH   = 4,
    parameter int unsigned MAX_READ_STREAK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
`ifdef SRAM_ARB_STATS_EN
    output logic [31:0]       stat_rd_grants,
    output logic [31:0]       stat_wr_grants,
    output logic [31:0]       stat_rd_stalls,
`endif
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_write_enable,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out
);

    localparam int unsigned STREAK_W = $clog2(MAX_READ_STREAK + 1);

    wr_entry_t            w_wr_entry;
    wr_entry_t            w_fifo_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_force_wr;
    gnt_e                 w_gnt;
    logic [STREAK_W-1:0]  r_streak;
    logic                 r_cmd_rd;
    logic [READ_LATENCY:0] r_rd_pipe;

    assign w_wr_entry   = '{addr: wr_req_addr, data: wr_req_data};
    assign w_push       = wr_req_valid && !w_fifo_full;
    assign w_pop        = (w_gnt == GNT_WR);
    assign wr_req_ready = !w_fifo_full;
    assign rd_req_ready = !rst && !w_force_wr;

    sram_arb_wr_fifo #(
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    (w_wr_entry),
        .i_pop     (w_pop),
        .o_head_c  (w_fifo_head),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty)
    );

    // Reads win unless a pending write has waited out a full read streak.
    always_comb begin
        w_force_wr = !w_fifo_empty && (r_streak == STREAK_W'(MAX_READ_STREAK));
        w_gnt      = GNT_IDLE;
        if (rd_req_valid && !w_force_wr) begin
            w_gnt = GNT_RD;
        end else if (!w_fifo_empty) begin
            w_gnt = GNT_WR;
        end
    end

    // Command register: each grant is presented to the SRAM for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr         <= '0;
            sram_write_enable <= 1'b0;
            sram_data_in      <= '0;
            r_cmd_rd          <= 1'b0;
            r_streak          <= '0;
        end else begin
            case (w_gnt)
                GNT_RD: begin
                    sram_addr         <= rd_req_addr;
                    sram_write_enable <= 1'b0;
                    r_cmd_rd          <= 1'b1;
                    r_streak          <= w_fifo_empty ? '0 : r_streak + STREAK_W'(1);
                end
                GNT_WR: begin
                    sram_addr         <= w_fifo_head.addr;
                    sram_data_in      <= w_fifo_head.data;
                    sram_write_enable <= 1'b1;
                    r_cmd_rd          <= 1'b0;
                    r_streak          <= '0;
                end
                default: begin
                    sram_write_enable <= 1'b0;
                    r_cmd_rd          <= 1'b0;
                    r_streak          <= '0;
                end
            endcase
        end
    end

    // In-flight read tracking; idle dummy reads never enter the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pipe     <= '0;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            r_rd_pipe     <= {r_rd_pipe[READ_LATENCY-1:0], r_cmd_rd};
            rd_resp_valid <= r_rd_pipe[READ_LATENCY];
            if (r_rd_pipe[READ_LATENCY]) begin
                rd_resp_data <= sram_data_out;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_grants <= '0;
            stat_wr_grants <= '0;
            stat_rd_stalls <= '0;
        end else begin
            if (w_gnt == GNT_RD) begin
                stat_rd_grants <= stat_rd_grants + 32'd1;
            end
            if (w_gnt == GNT_WR) begin
                stat_wr_grants <= stat_wr_grants + 32'd1;
            end
            if (rd_req_valid && !rd_req_ready) begin
                stat_rd_stalls <= stat_rd_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed scenarios push expectations, a negedge monitor checks responses and SRAM writes.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_write_enable;
    logic [DATA_W-1:0] sram_data_in;
    logic [DATA_W-1:0] sram_data_out;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0]       stat_rd_grants;
    logic [31:0]       stat_wr_grants;
    logic [31:0]       stat_rd_stalls;
`endif

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_addr       (rd_req_addr),
        .rd_resp_valid     (rd_resp_valid),
        .rd_resp_data      (rd_resp_data),
        .wr_req_valid      (wr_req_valid),
        .wr_req_ready      (wr_req_ready),
        .wr_req_addr       (wr_req_addr),
        .wr_req_data       (wr_req_data),
`ifdef SRAM_ARB_STATS_EN
        .stat_rd_grants    (stat_rd_grants),
        .stat_wr_grants    (stat_wr_grants),
        .stat_rd_stalls    (stat_rd_stalls),
`endif
        .sram_addr         (sram_addr),
        .sram_write_enable (sram_write_enable),
        .sram_data_in      (sram_data_in),
        .sram_data_out     (sram_data_out)
    );

    // SRAM model: latches the address each edge, returns ~addr READ_LATENCY cycles later.
    logic [ADDR_W-1:0] m_addr [READ_LATENCY+1];
    initial for (int i = 0; i <= READ_LATENCY; i++) m_addr[i] = '0;
    always @(posedge clk) begin
        m_addr[0] <= sram_addr;
        for (int i = 1; i <= READ_LATENCY; i++) m_addr[i] <= m_addr[i-1];
    end
    assign sram_data_out = DATA_W'(~m_addr[READ_LATENCY]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } rd_exp_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t mon_re;
    wr_exp_t mon_we;
    int      checks = 0;
    int      failures = 0;
    logic    wr_lat_exact = 1'b0;
    logic    ra, wa, rr, wrr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        return DATA_W'(~a);
    endfunction

    // Monitor: every response or SRAM write must match the head of its queue.
    always @(negedge clk) begin
        if (rd_resp_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got response 0x%0h at cycle %0d, required none", rd_resp_data, cyc);
            end else begin
                mon_re = rd_q.pop_front();
                check("rd_data", 32'(rd_resp_data), 32'(mon_re.data));
                check("rd_cycle", 32'(cyc), 32'(mon_re.cyc));
            end
        end
        if (sram_write_enable) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected: got write addr 0x%0h at cycle %0d, required none", sram_addr, cyc);
            end else begin
                mon_we = wr_q.pop_front();
                check("wr_addr", 32'(sram_addr), 32'(mon_we.addr));
                check("wr_data", 32'(sram_data_in), 32'(mon_we.data));
                if (mon_we.cyc >= 0) check("wr_cycle", 32'(cyc), 32'(mon_we.cyc));
            end
        end
    end

    // One clock of stimulus: record acceptances at the negedge, return just after the edge.
    task automatic tick(input logic [DATA_W-1:0] rexp, output logic o_ra, output logic o_wa,
                        output logic o_rr, output logic o_wr);
        @(negedge clk);
        o_rr = rd_req_ready;
        o_wr = wr_req_ready;
        o_ra = rd_req_valid && rd_req_ready;
        o_wa = wr_req_valid && wr_req_ready;
        if (o_ra) rd_q.push_back('{data: rexp, cyc: cyc + 1 + READ_LATENCY + 2});
        if (o_wa) wr_q.push_back('{addr: wr_req_addr, data: wr_req_data, cyc: wr_lat_exact ? cyc + 2 : -1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, ra, wa, rr, wrr);
    endtask

    logic [DATA_W-1:0] rd_tbl [4];
    int   n, k, nw, c0, first_edge, fourth_edge, fifth_edge, first_low, low_cnt;
    logic stalled, dropped, saw_resp, saw_we;

    initial begin
        rd_tbl[0] = 17'h1FFEF; rd_tbl[1] = 17'h1FFEE; rd_tbl[2] = 17'h1FFED; rd_tbl[3] = 17'h1FFEC;
        rst = 1'b1; rd_req_valid = 1'b0; rd_req_addr = '0;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_req_ready", 32'(rd_req_ready), 32'd0);
        check("rst_rd_resp_valid", 32'(rd_resp_valid), 32'd0);
        check("rst_rd_resp_data", 32'(rd_resp_data), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_we", 32'(sram_write_enable), 32'd0);
        check("rst_sram_data_in", 32'(sram_data_in), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_wr_ready", 32'(wr_req_ready), 32'd1);
        check("post_rst_rd_ready", 32'(rd_req_ready), 32'd1);

        // Starvation: one queued write, reads held.
        wr_req_valid = 1'b1; wr_req_addr = 20'h00200; wr_req_data = 17'h05555;
        tick('0, ra, wa, rr, wrr);
        check("starve_wr_enq", 32'(wa), 32'd1);
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 20'h00300;
        n = 0; stalled = 1'b0;
        for (int i = 0; i < 20 && !stalled; i++) begin
            tick(exp_rd(rd_req_addr), ra, wa, rr, wrr);
            if (!rr) stalled = 1'b1;
            else if (ra) begin n++; rd_req_addr++; end
        end
        check("starve_stalled", 32'(stalled), 32'd1);
        check("starve_rd_grants", 32'(n), 32'd8);
`ifdef SRAM_ARB_STATS_EN
        check("stat_rd_grants", stat_rd_grants, 32'd8);
        check("stat_wr_grants", stat_wr_grants, 32'd1);
        check("stat_rd_stalls", stat_rd_stalls, 32'd1);
`endif
        tick(exp_rd(rd_req_addr), ra, wa, rr, wrr);
        check("starve_resume", 32'(ra), 32'd1);
        rd_req_valid = 1'b0;
        idle(10);

        // Reads only: four back-to-back reads.
        rd_req_valid = 1'b1; rd_req_addr = 20'h00010; k = 0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            tick(rd_tbl[k], ra, wa, rr, wrr);
            if (ra) begin k++; rd_req_addr++; end
        end
        rd_req_valid = 1'b0;
        check("rdonly_accepts", 32'(k), 32'd4);
        idle(12);

        // Writes only: four writes, each issued one cycle after its enqueue.
        wr_lat_exact = 1'b1;
        wr_req_valid = 1'b1; wr_req_addr = 20'h00100; wr_req_data = 17'h0AAAA;
        k = 0; dropped = 1'b0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            tick('0, ra, wa, rr, wrr);
            if (!wrr) dropped = 1'b1;
            if (wa) begin k++; wr_req_addr++; wr_req_data++; end
        end
        wr_req_valid = 1'b0;
        wr_lat_exact = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick('0, ra, wa, rr, wrr);
            if (!wrr) dropped = 1'b1;
        end
        check("wronly_enqueues", 32'(k), 32'd4);
        check("wronly_ready_held", 32'(dropped), 32'd0);

        // Full FIFO: saturating reads, five writes offered back-to-back.
        rd_req_valid = 1'b1; rd_req_addr = 20'h00400;
        wr_req_valid = 1'b1; wr_req_addr = 20'h00500; wr_req_data = 17'h01000;
        nw = 0; first_edge = 0; fourth_edge = 0; fifth_edge = 0; first_low = -1; low_cnt = 0;
        for (int i = 0; i < 40 && nw < 5; i++) begin
            c0 = cyc;
            tick(exp_rd(rd_req_addr), ra, wa, rr, wrr);
            if (ra) rd_req_addr++;
            if (!wrr) begin
                low_cnt++;
                if (first_low < 0) first_low = c0 + 1;
            end
            if (wa) begin
                if (nw == 0) first_edge = c0 + 1;
                if (nw == 3) fourth_edge = c0 + 1;
                if (nw == 4) fifth_edge = c0 + 1;
                nw++; wr_req_addr++; wr_req_data++;
            end
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        check("full_enqueues", 32'(nw), 32'd5);
        check("full_ready_drop_edge", 32'(first_low), 32'(fourth_edge + 1));
        check("full_ready_low_cycles", 32'(low_cnt), 32'd6);
        check("full_fifth_accept_delay", 32'(fifth_edge - first_edge), 32'd10);
        idle(20);

        // Reset mid-operation: three reads in flight, two writes queued.
        rd_req_valid = 1'b1; rd_req_addr = 20'h00600;
        wr_req_valid = 1'b1; wr_req_addr = 20'h00700; wr_req_data = 17'h0BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) wr_req_valid = 1'b0;
            tick(exp_rd(rd_req_addr), ra, wa, rr, wrr);
            rd_req_addr++; wr_req_addr++;
        end
        rd_req_valid = 1'b0;
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_wr_ready", 32'(wr_req_ready), 32'd1);
        check("midrst_sram_we", 32'(sram_write_enable), 32'd0);
        saw_resp = 1'b0; saw_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rd_resp_valid) saw_resp = 1'b1;
            if (sram_write_enable) saw_we = 1'b1;
            if (!wr_req_ready) dropped = 1'b1;
        end
        check("midrst_no_resp", 32'(saw_resp), 32'd0);
        check("midrst_no_write", 32'(saw_we), 32'd0);
        check("midrst_ready_held", 32'(wr_req_ready), 32'd1);

        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
